// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and digit check for the BCD-to-binary converter
package bcd_pkg;
    localparam int DIGIT_MAX   = 9;
    localparam int CORR_THRESH = 8;
    localparam int CORR_SUB    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    function automatic logic is_bcd_valid(input logic [3:0] digit);
        return digit <= 4'(DIGIT_MAX);
    endfunction
endpackage

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: one reverse double-dabble correction, subtract 3 from a digit that reached 8 or more
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);
    assign d_out = (d_in >= 4'(CORR_THRESH)) ? d_in - 4'(CORR_SUB) : d_in;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary encoder, one shift-and-correct step per clock
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_sh, bcd_corr;
    logic [BIN_W-1:0]   bin_q, bin_d, bin_sh;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               all_valid;

    // The BCD LSB falls into the binary MSB as the pair shifts right
    assign bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_sh = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        bcd_digit_corr u_corr (
            .d_in  (bcd_sh[4*i +: 4]),
            .d_out (bcd_corr[4*i +: 4])
        );
    end

    always_comb begin
        all_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) all_valid &= is_bcd_valid(bcd_in[4*k +: 4]);
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        bin_out_d = bin_out_q;
        case (state_q)
            ST_IDLE: if (start) begin
                if (all_valid) begin
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_CONV;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_CONV: begin
                bcd_d = bcd_corr;
                bin_d = bin_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d   = ST_DONE;
                    bin_out_d = bin_sh;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            bin_out_q <= bin_out_d;
        end
    end

    assign busy    = (state_q == ST_CONV);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign bin_out = bin_out_q;
endmodule
